// File: rtl/cfu_simd_mac_quant.sv
// SIMD int8 multiply-accumulate CFU with a multi-cycle requantization pipeline.
// Define CFU_SAT_ACC_EN to make accumulator and bias additions saturate instead of wrapping.
module cfu_simd_mac_quant #(
    parameter int LANES        = 4,
    parameter int NUM_ACC      = 4,
    parameter int INPUT_OFFSET = 128,
    parameter int ACT_MIN      = -128,
    parameter int ACT_MAX      = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [9:0]           cmd_payload_function_id,
    input  logic [8*LANES-1:0]   cmd_payload_inputs_0,
    input  logic [8*LANES-1:0]   cmd_payload_inputs_1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_payload_outputs_0
);

    localparam int W = 8 * LANES;
    localparam logic [6:0] OP_CLEAR   = 7'd0;
    localparam logic [6:0] OP_MAC     = 7'd1;
    localparam logic [6:0] OP_SETQ0   = 7'd2;
    localparam logic [6:0] OP_SETQ1   = 7'd3;
    localparam logic [6:0] OP_LOAD    = 7'd4;
    localparam logic [6:0] OP_REQUANT = 7'd5;
    localparam logic signed [17:0] IN_OFF    = 18'(INPUT_OFFSET);
    localparam logic signed [63:0] ACT_MIN64 = 64'(ACT_MIN);
    localparam logic signed [63:0] ACT_MAX64 = 64'(ACT_MAX);
    localparam logic [2:0]         SEL_MASK  = 3'(NUM_ACC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MUL, S_SHIFT, S_CLAMP, S_RESP
    } state_t;

    // Accumulator add: saturating when CFU_SAT_ACC_EN is defined, otherwise modulo 2^32.
    function automatic logic [31:0] acc_add(input logic [31:0] x, input logic [31:0] y);
`ifdef CFU_SAT_ACC_EN
        logic [32:0] s;
        s = {x[31], x} + {y[31], y};
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            return s[31:0];
        end
`else
        return x + y;
`endif
    endfunction

    state_t              state_r, state_s;
    logic [31:0]         acc_r [8];
    logic [31:0]         bias_r, out_off_r, mult_r;
    logic signed [5:0]   shift_r, shift_clamp_s;
    logic [2:0]          sel_r, sel_s;
    logic [31:0]         t_r, r_r;
    logic signed [63:0]  p_r;
    logic                rsp_valid_r;
    logic [31:0]         rsp_data_r;

    logic                accept_s;
    logic [6:0]          opcode_s;
    logic [31:0]         scalar_a_s, scalar_b_s, dot_s, mac_sum_s, clamp_s;
    logic signed [17:0]  lane_a_s [LANES];
    logic signed [17:0]  lane_b_s [LANES];
    logic signed [17:0]  lane_p_s [LANES];
    logic signed [63:0]  t_ext_s, m_ext_s, mul_s, sum64_s;
    logic signed [31:0]  b_signed_s;
    logic [6:0]          rnd_sh_s, ash_s;

    assign opcode_s  = cmd_payload_function_id[9:3];
    assign sel_s     = cmd_payload_function_id[2:0] & SEL_MASK;
    assign cmd_ready = !reset && (state_r == S_IDLE) && !rsp_valid_r;
    assign accept_s  = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_valid_r;
    assign rsp_payload_outputs_0 = rsp_data_r;

    if (W >= 32) begin : g_wide
        assign scalar_a_s = cmd_payload_inputs_0[31:0];
        assign scalar_b_s = cmd_payload_inputs_1[31:0];
    end else begin : g_narrow
        assign scalar_a_s = {{(32 - W){1'b0}}, cmd_payload_inputs_0};
        assign scalar_b_s = {{(32 - W){1'b0}}, cmd_payload_inputs_1};
    end

    // Per-lane (act + offset) * filter at 18 bits, summed at 32 bits.
    always_comb begin
        dot_s = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            lane_a_s[i] = $signed({{10{cmd_payload_inputs_0[8*i+7]}}, cmd_payload_inputs_0[8*i +: 8]}) + IN_OFF;
            lane_b_s[i] = $signed({{10{cmd_payload_inputs_1[8*i+7]}}, cmd_payload_inputs_1[8*i +: 8]});
            lane_p_s[i] = lane_a_s[i] * lane_b_s[i];
            dot_s       = dot_s + {{14{lane_p_s[i][17]}}, lane_p_s[i]};
        end
    end

    assign mac_sum_s = acc_add(acc_r[sel_s], dot_s);

    // Shift operand limited to [-31,30] so both shift distances stay in range.
    always_comb begin
        b_signed_s = scalar_b_s;
        if (b_signed_s < -32'sd31) begin
            shift_clamp_s = -6'sd31;
        end else if (b_signed_s > 32'sd30) begin
            shift_clamp_s = 6'sd30;
        end else begin
            shift_clamp_s = b_signed_s[5:0];
        end
    end

    assign rnd_sh_s = 7'd30 - {shift_r[5], shift_r};
    assign ash_s    = 7'd31 - {shift_r[5], shift_r};
    assign t_ext_s  = {{32{t_r[31]}}, t_r};
    assign m_ext_s  = {{32{mult_r[31]}}, mult_r};
    assign mul_s    = (t_ext_s * m_ext_s) + (64'sd1 <<< rnd_sh_s);
    assign sum64_s  = {{32{r_r[31]}}, r_r} + {{32{out_off_r[31]}}, out_off_r};

    // Final output clamp to the activation range.
    always_comb begin
        if (sum64_s < ACT_MIN64) begin
            clamp_s = ACT_MIN64[31:0];
        end else if (sum64_s > ACT_MAX64) begin
            clamp_s = ACT_MAX64[31:0];
        end else begin
            clamp_s = sum64_s[31:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: only REQUANT leaves IDLE; RESP waits for the handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (opcode_s == OP_REQUANT)) begin
                    state_s = S_BIAS;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BIAS:  state_s = S_MUL;
            S_MUL:   state_s = S_SHIFT;
            S_SHIFT: state_s = S_CLAMP;
            S_CLAMP: state_s = S_RESP;
            S_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Requant pipeline registers, one stage per FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_r <= 32'd0;
            p_r <= 64'sd0;
            r_r <= 32'd0;
        end else begin
            case (state_r)
                S_BIAS:  t_r <= acc_add(acc_r[sel_r], bias_r);
                S_MUL:   p_r <= mul_s;
                S_SHIFT: r_r <= 32'(p_r >>> ash_s);
                default: t_r <= t_r;
            endcase
        end
    end

    // Architectural state and response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                acc_r[i] <= 32'd0;
            end
            bias_r      <= 32'd0;
            out_off_r   <= 32'd0;
            mult_r      <= 32'd0;
            shift_r     <= 6'sd0;
            sel_r       <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
        end else if (accept_s) begin
            sel_r       <= sel_s;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= 32'd0;
            case (opcode_s)
                OP_CLEAR: acc_r[sel_s] <= 32'd0;
                OP_MAC: begin
                    acc_r[sel_s] <= mac_sum_s;
                    rsp_data_r   <= mac_sum_s;
                end
                OP_SETQ0: begin
                    bias_r    <= scalar_a_s;
                    out_off_r <= scalar_b_s;
                end
                OP_SETQ1: begin
                    mult_r  <= scalar_a_s;
                    shift_r <= shift_clamp_s;
                end
                OP_LOAD: begin
                    acc_r[sel_s] <= scalar_a_s;
                    rsp_data_r   <= scalar_a_s;
                end
                OP_REQUANT: rsp_valid_r <= 1'b0;
                default:    rsp_data_r  <= 32'd0;
            endcase
        end else if (state_r == S_CLAMP) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= clamp_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

endmodule
